// File: rtl/axil_slave_fifo_bridge.sv
// axil_slave_fifo_bridge
//   AXI4-Lite slave front-end for the AXI2SDRAM controller.
//   - AW and W are captured independently, in either order. Once both are held,
//     one {addr,wdata,wstrb} write command is pushed. Out-of-window writes get
//     SLVERR and push nothing.
//   - Reads are pushed to the read-address FIFO, with up to MAX_RD_OUTSTANDING
//     reads in flight. Data returns in order from a first-word-fall-through
//     read-data FIFO. An out-of-window read waits until all earlier reads have
//     returned, then gets SLVERR with zero data.
// Ports
//   s_axil_clk / s_axil_resetn     clock, synchronous ACTIVE-HIGH reset
//   s_axil_aw*/w*/b*/ar*/r*        AXI4-Lite slave channels
//   WCMD_PUSH/WCMD_DATA/WCMD_FULL  write-command FIFO push side
//   RCMD_PUSH/RCMD_ADDR/RCMD_FULL  read-address FIFO push side
//   RDATA_POP/RDATA_IN/RDATA_EMPTY read-data FIFO pop side (FWFT)
// Optional feature (macro AXIL_BRIDGE_STATS_EN)
//   Adds STAT_CLR in, plus STAT_WR_CNT, STAT_RD_CNT and STAT_ERR_CNT
//   handshake counters.
module axil_slave_fifo_bridge #(
  parameter int unsigned           ADDR_WIDTH         = 32,
  parameter int unsigned           DATA_WIDTH         = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE          = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE          = ADDR_WIDTH'(32'h0100_0000),
  parameter int unsigned           MAX_RD_OUTSTANDING = 4
) (
  input  logic                                           s_axil_clk,
  input  logic                                           s_axil_resetn,
  input  logic [ADDR_WIDTH-1:0]                          s_axil_awaddr,
  input  logic                                           s_axil_awvalid,
  output logic                                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]                          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]                        s_axil_wstrb,
  input  logic                                           s_axil_wvalid,
  output logic                                           s_axil_wready,
  output logic [1:0]                                     s_axil_bresp,
  output logic                                           s_axil_bvalid,
  input  logic                                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]                          s_axil_araddr,
  input  logic                                           s_axil_arvalid,
  output logic                                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]                          s_axil_rdata,
  output logic [1:0]                                     s_axil_rresp,
  output logic                                           s_axil_rvalid,
  input  logic                                           s_axil_rready,
  output logic                                           WCMD_PUSH,
  output logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8-1:0]  WCMD_DATA,
  input  logic                                           WCMD_FULL,
  output logic                                           RCMD_PUSH,
  output logic [ADDR_WIDTH-1:0]                          RCMD_ADDR,
  input  logic                                           RCMD_FULL,
  output logic                                           RDATA_POP,
  input  logic [DATA_WIDTH-1:0]                          RDATA_IN,
  input  logic                                           RDATA_EMPTY
`ifdef AXIL_BRIDGE_STATS_EN
  ,
  input  logic                                           STAT_CLR,
  output logic [31:0]                                    STAT_WR_CNT,
  output logic [31:0]                                    STAT_RD_CNT,
  output logic [15:0]                                    STAT_ERR_CNT
`endif
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned WCMD_W = ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int unsigned CNT_W  = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Window check at ADDR_WIDTH+1 bits; an address below the base wraps to a huge offset.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, ADDR_BASE};
    return off < {1'b0, ADDR_SIZE};
  endfunction

  // Write path state
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wcmd_push_q, wcmd_push_d;
  logic [WCMD_W-1:0]     wcmd_data_q, wcmd_data_d;

  // Read path state
  logic                  arready_q, arready_d;
  logic                  rcmd_push_q, rcmd_push_d;
  logic [ADDR_WIDTH-1:0] rcmd_addr_q, rcmd_addr_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  err_pend_q, err_pend_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_pop_c;

  // Write capture, issue and response
  always_comb begin
    logic wr_in_range;
    logic b_free;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wcmd_push_d = 1'b0;
    wcmd_data_d = wcmd_data_q;
    wr_in_range = in_window(awaddr_q);
    b_free      = ~bvalid_q | s_axil_bready;

    if (s_axil_awvalid && awready_q) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr;
    end
    if (s_axil_wvalid && wready_q) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end
    if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end
    // A full command FIFO only stalls in-window writes; errors never touch it.
    if (aw_held_q && w_held_q && b_free && (!wr_in_range || !WCMD_FULL)) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_range) begin
        wcmd_push_d = 1'b1;
        wcmd_data_d = {awaddr_q, wdata_q, wstrb_q};
      end
    end
    awready_d = ~aw_held_d;
    wready_d  = ~w_held_d;
  end

  // Read accept, outstanding count and in-order return
  always_comb begin
    logic ar_in_range;
    logic r_free;
    logic ar_push_pending;
    rcmd_push_d = 1'b0;
    rcmd_addr_d = rcmd_addr_q;
    err_pend_d  = err_pend_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    rdata_pop_c = 1'b0;
    ar_in_range = in_window(s_axil_araddr);
    r_free      = ~rvalid_q | s_axil_rready;

    if (s_axil_arvalid && arready_q) begin
      if (ar_in_range) begin
        rcmd_push_d = 1'b1;
        rcmd_addr_d = s_axil_araddr;
      end else begin
        err_pend_d = 1'b1;
      end
    end
    if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
    if (err_pend_q && r_free && (rd_cnt_q == '0)) begin
      rvalid_d   = 1'b1;
      rresp_d    = RESP_SLVERR;
      rdata_d    = '0;
      err_pend_d = 1'b0;
    end else if ((rd_cnt_q != '0) && !RDATA_EMPTY && r_free && !s_axil_resetn) begin
      rdata_pop_c = 1'b1;
      rdata_d     = RDATA_IN;
      rresp_d     = RESP_OKAY;
      rvalid_d    = 1'b1;
    end
    rd_cnt_d = rd_cnt_q + CNT_W'(rcmd_push_d) - CNT_W'(rdata_pop_c);

    // RCMD_FULL lags a push by a cycle, so hold off while a push is being made or presented.
    // An out-of-window AR is only offered ready when nothing is outstanding.
    ar_push_pending = rcmd_push_d | rcmd_push_q;
    arready_d = ~RCMD_FULL & (rd_cnt_d < CNT_W'(MAX_RD_OUTSTANDING)) & ~err_pend_d
              & ~ar_push_pending
              & ((rd_cnt_d == '0) | (s_axil_arvalid & ar_in_range));
  end

  always_ff @(posedge s_axil_clk) begin
    if (s_axil_resetn) begin
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      wcmd_push_q <= 1'b0;
      wcmd_data_q <= '0;
      arready_q   <= 1'b0;
      rcmd_push_q <= 1'b0;
      rcmd_addr_q <= '0;
      rd_cnt_q    <= '0;
      err_pend_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      wcmd_push_q <= wcmd_push_d;
      wcmd_data_q <= wcmd_data_d;
      arready_q   <= arready_d;
      rcmd_push_q <= rcmd_push_d;
      rcmd_addr_q <= rcmd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      err_pend_q  <= err_pend_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign WCMD_PUSH      = wcmd_push_q;
  assign WCMD_DATA      = wcmd_data_q;
  assign RCMD_PUSH      = rcmd_push_q;
  assign RCMD_ADDR      = rcmd_addr_q;
  // FWFT pop must coincide with the edge that captures RDATA_IN, so it is combinational.
  assign RDATA_POP      = rdata_pop_c;

`ifdef AXIL_BRIDGE_STATS_EN
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_err_q, stat_err_d;

  // Handshake counters; a B and an R error in the same cycle both count.
  always_comb begin
    logic b_hs;
    logic r_hs;
    b_hs       = bvalid_q & s_axil_bready;
    r_hs       = rvalid_q & s_axil_rready;
    stat_wr_d  = stat_wr_q + 32'(b_hs);
    stat_rd_d  = stat_rd_q + 32'(r_hs);
    stat_err_d = stat_err_q + 16'(b_hs & (bresp_q == RESP_SLVERR))
                            + 16'(r_hs & (rresp_q == RESP_SLVERR));
  end

  always_ff @(posedge s_axil_clk) begin
    if (s_axil_resetn || STAT_CLR) begin
      stat_wr_q  <= '0;
      stat_rd_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_wr_q  <= stat_wr_d;
      stat_rd_q  <= stat_rd_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign STAT_WR_CNT  = stat_wr_q;
  assign STAT_RD_CNT  = stat_rd_q;
  assign STAT_ERR_CNT = stat_err_q;
`endif

endmodule

// File: tb/tb_axil_slave_fifo_bridge.sv
// Directed testbench for axil_slave_fifo_bridge (default build, 32-bit, MAX=4).
module tb_axil_slave_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        wcmd_push;
  logic [67:0] wcmd_data;
  logic        wcmd_full;
  logic        rcmd_push;
  logic [31:0] rcmd_addr;
  logic        rcmd_full;
  logic        rdata_pop;
  logic [31:0] rdata_in;
  logic        rdata_empty;

  always #5 clk = ~clk;

  axil_slave_fifo_bridge dut (
    .s_axil_clk     (clk),
    .s_axil_resetn  (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .WCMD_PUSH      (wcmd_push),
    .WCMD_DATA      (wcmd_data),
    .WCMD_FULL      (wcmd_full),
    .RCMD_PUSH      (rcmd_push),
    .RCMD_ADDR      (rcmd_addr),
    .RCMD_FULL      (rcmd_full),
    .RDATA_POP      (rdata_pop),
    .RDATA_IN       (rdata_in),
    .RDATA_EMPTY    (rdata_empty)
  );

  int errors = 0;
  int checks = 0;

  int          wpush_cnt = 0;
  int          rpush_cnt = 0;
  int          pop_cnt   = 0;
  logic [67:0] wpush_last = '0;
  logic [31:0] rcmd_q[$];
  logic [31:0] fifo_q[$];
  logic [33:0] r_q[$];
  logic        aw_hs_seen, w_hs_seen, ar_hs_seen, pop_now;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void fifo_drive();
    rdata_empty = (fifo_q.size() == 0);
    rdata_in    = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endfunction

  // One clock: observe at the falling edge, then update the FIFO model and drop accepted valids.
  task automatic tick();
    @(negedge clk);
    aw_hs_seen = awvalid & awready;
    w_hs_seen  = wvalid & wready;
    ar_hs_seen = arvalid & arready;
    pop_now    = rdata_pop;
    if (wcmd_push) begin wpush_cnt++; wpush_last = wcmd_data; end
    if (rcmd_push) begin rpush_cnt++; rcmd_q.push_back(rcmd_addr); end
    if (rvalid && rready) r_q.push_back({rresp, rdata});
    if (pop_now) pop_cnt++;
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (aw_hs_seen) awvalid = 1'b0;
    if (w_hs_seen)  wvalid  = 1'b0;
    if (ar_hs_seen) arvalid = 1'b0;
    fifo_drive();
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) tick();
    check("aw_w_accept", 128'(awvalid | wvalid), 128'(0));
  endtask

  task automatic wait_b(input string tag, input logic [1:0] exp_resp);
    for (int i = 0; i < 20 && !bvalid; i++) tick();
    check({tag, "_bvalid"}, 128'(bvalid), 128'(1));
    check({tag, "_bresp"}, 128'(bresp), 128'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_ar(input logic [31:0] a, input int budget, output bit ok);
    araddr = a; arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ar_hs_seen) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_r(input int n, input int budget);
    for (int i = 0; i < budget && r_q.size() < n; i++) tick();
    check("r_count", 128'(r_q.size()), 128'(n));
  endtask

  bit          ok;
  int          base;
  logic [31:0] words[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; wcmd_full = 1'b0; rcmd_full = 1'b0;
    fifo_drive();
    tick(); tick();
    // Reset state
    check("rst_awready", 128'(awready), 128'(0));
    check("rst_wready",  128'(wready),  128'(0));
    check("rst_bvalid",  128'(bvalid),  128'(0));
    check("rst_arready", 128'(arready), 128'(0));
    check("rst_rvalid",  128'(rvalid),  128'(0));
    check("rst_wpush",   128'(wcmd_push), 128'(0));
    rst = 1'b0;
    tick();
    check("post_rst_awready", 128'(awready), 128'(1));
    check("post_rst_wready",  128'(wready),  128'(1));
    check("post_rst_arready", 128'(arready), 128'(1));

    // 1: W three cycles ahead of AW
    wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    check("t1_w_taken", 128'(wvalid), 128'(0));
    tick(); tick();
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    wait_b("t1", 2'b00);
    check("t1_push_cnt", 128'(wpush_cnt), 128'(1));
    check("t1_push_data", 128'(wpush_last), 128'({32'h10, 32'hA5A5_0001, 4'hF}));
    check("t1_awready", 128'(awready), 128'(1));
    check("t1_wready",  128'(wready),  128'(1));

    // 2: out-of-window write, then normal writes including the window edges
    axi_write(32'h0200_0000, 32'h1111_2222, 4'hF);
    wait_b("t2_oor", 2'b10);
    check("t2_oor_nopush", 128'(wpush_cnt), 128'(1));
    axi_write(32'h20, 32'h1234_5678, 4'h3);
    wait_b("t2_ok", 2'b00);
    check("t2_push_data", 128'(wpush_last), 128'({32'h20, 32'h1234_5678, 4'h3}));
    axi_write(32'h00FF_FFFC, 32'h0BAD_F00D, 4'h8);
    wait_b("t2_top", 2'b00);
    check("t2_top_data", 128'(wpush_last), 128'({32'h00FF_FFFC, 32'h0BAD_F00D, 4'h8}));
    axi_write(32'h0100_0000, 32'h5555_AAAA, 4'hF);
    wait_b("t2_edge", 2'b10);
    check("t2_push_cnt", 128'(wpush_cnt), 128'(3));

    // 3: command FIFO full stalls an in-window write
    wcmd_full = 1'b1;
    axi_write(32'h30, 32'hDEAD_BEEF, 4'hA);
    repeat (5) tick();
    check("t3_nopush",  128'(wpush_cnt), 128'(3));
    check("t3_nobvalid", 128'(bvalid), 128'(0));
    check("t3_awblock", 128'(awready), 128'(0));
    check("t3_wblock",  128'(wready),  128'(0));
    wcmd_full = 1'b0;
    tick();
    check("t3_push_now", 128'(wcmd_push), 128'(1));
    check("t3_push_data", 128'(wcmd_data), 128'({32'h30, 32'hDEAD_BEEF, 4'hA}));
    wait_b("t3", 2'b00);

    // 4: five reads, only four may be outstanding
    rcmd_q.delete(); r_q.delete(); base = rpush_cnt;
    axi_ar(32'h100, 10, ok);      check("t4_ar0", 128'(ok), 128'(1));
    axi_ar(32'h104, 10, ok);      check("t4_ar1", 128'(ok), 128'(1));
    axi_ar(32'h00FF_FFFC, 10, ok); check("t4_ar2", 128'(ok), 128'(1));
    axi_ar(32'h10C, 10, ok);      check("t4_ar3", 128'(ok), 128'(1));
    axi_ar(32'h110, 8, ok);       check("t4_ar4_stall", 128'(ok), 128'(0));
    check("t4_arready_low", 128'(arready), 128'(0));
    check("t4_push_cnt", 128'(rpush_cnt - base), 128'(4));
    check("t4_addr2", 128'(rcmd_q[2]), 128'(32'h00FF_FFFC));
    words[0] = 32'hD000_0000; words[1] = 32'hD000_0001; words[2] = 32'hD000_0002;
    words[3] = 32'hD000_0003; words[4] = 32'hD000_0004;
    for (int i = 0; i < 4; i++) fifo_q.push_back(words[i]);
    fifo_drive();
    rready = 1'b1;
    wait_r(4, 40);
    for (int i = 0; i < 4; i++) check($sformatf("t4_r%0d", i), 128'(r_q[i]), 128'({2'b00, words[i]}));
    repeat (4) tick();
    check("t4_ar4_taken", 128'(arvalid), 128'(0));
    check("t4_push5", 128'(rpush_cnt - base), 128'(5));
    check("t4_addr4", 128'(rcmd_q[4]), 128'(32'h110));
    fifo_q.push_back(words[4]);
    fifo_drive();
    wait_r(5, 20);
    check("t4_r4", 128'(r_q[4]), 128'({2'b00, words[4]}));

    // 5: out-of-window read waits for two outstanding reads
    rready = 1'b0; r_q.delete(); base = rpush_cnt;
    axi_ar(32'h200, 10, ok); check("t5_ar0", 128'(ok), 128'(1));
    axi_ar(32'h204, 10, ok); check("t5_ar1", 128'(ok), 128'(1));
    axi_ar(32'h0300_0000, 6, ok); check("t5_oor_stall", 128'(ok), 128'(0));
    check("t5_arready_low", 128'(arready), 128'(0));
    fifo_q.push_back(32'hE000_0000); fifo_q.push_back(32'hE000_0001);
    fifo_drive();
    rready = 1'b1;
    wait_r(3, 60);
    check("t5_r0", 128'(r_q[0]), 128'({2'b00, 32'hE000_0000}));
    check("t5_r1", 128'(r_q[1]), 128'({2'b00, 32'hE000_0001}));
    check("t5_r_err", 128'(r_q[2]), 128'({2'b10, 32'h0}));
    check("t5_push_cnt", 128'(rpush_cnt - base), 128'(2));

    // 6: R back-pressure keeps data stable, then reset mid-read
    rready = 1'b0; r_q.delete();
    fifo_q.push_back(32'hCAFE_0001); fifo_q.push_back(32'hCAFE_0002);
    fifo_drive();
    axi_ar(32'h300, 10, ok); check("t6_ar0", 128'(ok), 128'(1));
    axi_ar(32'h304, 10, ok); check("t6_ar1", 128'(ok), 128'(1));
    tick();
    base = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_hold_rdata%0d", i), 128'(rdata), 128'(32'hCAFE_0001));
      check($sformatf("t6_hold_nopop%0d", i), 128'(pop_cnt - base), 128'(0));
    end
    check("t6_rvalid", 128'(rvalid), 128'(1));
    rst = 1'b1;
    tick();
    check("t6_rst_rvalid",  128'(rvalid),  128'(0));
    check("t6_rst_rdata",   128'(rdata),   128'(0));
    check("t6_rst_arready", 128'(arready), 128'(0));
    check("t6_rst_awready", 128'(awready), 128'(0));
    check("t6_rst_rpush",   128'(rcmd_push), 128'(0));
    check("t6_rst_pop",     128'(rdata_pop), 128'(0));
    rst = 1'b0;
    base = pop_cnt;
    repeat (5) tick();
    // Stale FIFO data with nothing outstanding must not be popped
    check("t6_no_stale_pop", 128'(pop_cnt - base), 128'(0));
    check("t6_post_rvalid",  128'(rvalid),  128'(0));
    check("t6_post_arready", 128'(arready), 128'(1));
    fifo_q.delete();
    fifo_drive();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
